seg7_scan_reader: RTL and testbench

Receive-side counterpart of the BCD-to-seven-segment decoder. It watches a time-multiplexed seven-segment display bus (active-low anodes and active-low segments a..g), waits for each digit's pattern to settle, and converts it back to BCD. It keeps one BCD value, blank flag and error flag per digit position. It sits in the stopwatch/display path as a loopback monitor, so on-chip logic and benches can read back exactly what the display shows.

---
 rtl/seg7_pkg.sv | 43 ++++
 rtl/seg7_pattern_to_bcd.sv | 34 +++
 rtl/seg7_scan_reader.sv | 139 +++++++++++++
 tb/tb_seg7_scan_reader.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Seven-segment pattern table and scan-reader state encoding, shared by the
// decoder and the scan reader so both ends agree on one table.
package seg7_pkg;

    // Active-low segments in [0:6] order: bit 0 = a ... bit 6 = g.
    localparam logic [0:6] SEG_0     = 7'b0000001;
    localparam logic [0:6] SEG_1     = 7'b1001111;
    localparam logic [0:6] SEG_2     = 7'b0010010;
    localparam logic [0:6] SEG_3     = 7'b0000110;
    localparam logic [0:6] SEG_4     = 7'b1001100;
    localparam logic [0:6] SEG_5     = 7'b0100100;
    localparam logic [0:6] SEG_6     = 7'b0100000;
    localparam logic [0:6] SEG_7     = 7'b0001111;
    localparam logic [0:6] SEG_8     = 7'b0000000;
    localparam logic [0:6] SEG_9     = 7'b0000100;
    localparam logic [0:6] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        HELD
    } state_e;

    // Forward mapping used on the drive side; BCD values above 9 blank the digit.
    function automatic logic [0:6] bcd_to_seg(input logic [3:0] bcd);
        logic [0:6] seg;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg7_pattern_to_bcd.sv
// Combinational inverse of the seven-segment table: pattern -> {valid, blank, bcd}.
module seg7_pattern_to_bcd
    import seg7_pkg::*;
(
    input  logic [0:6] pattern,
    output logic       valid,
    output logic       blank,
    output logic [3:0] bcd
);

    always_comb begin
        valid = 1'b1;
        blank = 1'b0;
        bcd   = 4'd0;
        case (pattern)
            SEG_0: bcd = 4'd0;
            SEG_1: bcd = 4'd1;
            SEG_2: bcd = 4'd2;
            SEG_3: bcd = 4'd3;
            SEG_4: bcd = 4'd4;
            SEG_5: bcd = 4'd5;
            SEG_6: bcd = 4'd6;
            SEG_7: bcd = 4'd7;
            SEG_8: bcd = 4'd8;
            SEG_9: bcd = 4'd9;
            SEG_BLANK: begin
                valid = 1'b0;
                blank = 1'b1;
            end
            default: valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_scan_reader.sv
// Loopback monitor for a multiplexed seven-segment bus: waits for each digit's
// pattern to settle, decodes it back to BCD and keeps per-digit state.
module seg7_scan_reader
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS    = 4,
    parameter int unsigned STABLE_CYCLES = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_DIGITS-1:0]   an_in,
    input  logic [0:6]              seg_in,
    output logic [4*NUM_DIGITS-1:0] digits_out,
    output logic [NUM_DIGITS-1:0]   blank_out,
    output logic [NUM_DIGITS-1:0]   err_out,
    output logic                    commit,
    output logic                    frame_valid
);

    localparam int unsigned SW = NUM_DIGITS + 7;
    localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

    state_e                  state_q, state_d;
    logic [SW-1:0]           s_q, s_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
    logic [NUM_DIGITS-1:0]   blank_q, blank_d;
    logic [NUM_DIGITS-1:0]   err_q, err_d;
    logic [NUM_DIGITS-1:0]   seen_q, seen_d;
    logic                    commit_q, commit_d;
    logic                    frame_q, frame_d;

    logic [SW-1:0]         sample_in;
    logic [NUM_DIGITS-1:0] s_an;
    logic [0:6]            s_seg;
    logic [NUM_DIGITS-1:0] commit_mask;
    logic [NUM_DIGITS-1:0] seen_next;
    logic                  do_commit;
    logic                  pat_valid;
    logic                  pat_blank;
    logic [3:0]            pat_bcd;

    assign sample_in   = {an_in, seg_in};
    assign s_an        = s_q[SW-1:7];
    assign s_seg       = s_q[6:0];
    // s only reaches SETTLE with one anode low, so this is one-hot at commit time.
    assign commit_mask = ~s_an;

    seg7_pattern_to_bcd u_decode (
        .pattern (s_seg),
        .valid   (pat_valid),
        .blank   (pat_blank),
        .bcd     (pat_bcd)
    );

    always_comb begin
        state_d   = state_q;
        s_d       = s_q;
        cnt_d     = cnt_q;
        do_commit = 1'b0;
        if (sample_in != s_q) begin
            s_d     = sample_in;
            cnt_d   = '0;
            state_d = $onehot(~an_in) ? SETTLE : IDLE;
        end else if (state_q == SETTLE) begin
            if (cnt_q == CNT_LAST) begin
                do_commit = 1'b1;
                state_d   = HELD;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_comb begin
        digits_d  = digits_q;
        blank_d   = blank_q;
        err_d     = err_q;
        seen_d    = seen_q;
        seen_next = seen_q | commit_mask;
        commit_d  = do_commit;
        frame_d   = 1'b0;
        if (do_commit) begin
            for (int i = 0; i < int'(NUM_DIGITS); i++) begin
                if (commit_mask[i]) begin
                    if (pat_valid) begin
                        digits_d[4*i +: 4] = pat_bcd;
                        blank_d[i]         = 1'b0;
                        err_d[i]           = 1'b0;
                    end else if (pat_blank) begin
                        digits_d[4*i +: 4] = 4'd0;
                        blank_d[i]         = 1'b1;
                        err_d[i]           = 1'b0;
                    end else begin
                        err_d[i] = 1'b1;
                    end
                end
            end
            if (&seen_next) begin
                frame_d = 1'b1;
                seen_d  = '0;
            end else begin
                seen_d = seen_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            s_q      <= '1;
            cnt_q    <= '0;
            digits_q <= '0;
            blank_q  <= '1;
            err_q    <= '0;
            seen_q   <= '0;
            commit_q <= 1'b0;
            frame_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            s_q      <= s_d;
            cnt_q    <= cnt_d;
            digits_q <= digits_d;
            blank_q  <= blank_d;
            err_q    <= err_d;
            seen_q   <= seen_d;
            commit_q <= commit_d;
            frame_q  <= frame_d;
        end
    end

    assign digits_out  = digits_q;
    assign blank_out   = blank_q;
    assign err_out     = err_q;
    assign commit      = commit_q;
    assign frame_valid = frame_q;

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Randomised and directed bench for seg7_scan_reader against a run-length
// reference model of the display bus.
module tb_seg7_scan_reader;

    localparam int N  = 4;
    localparam int SC = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   an_in;
    logic [0:6]     seg_in;
    logic [4*N-1:0] digits_out;
    logic [N-1:0]   blank_out;
    logic [N-1:0]   err_out;
    logic           commit;
    logic           frame_valid;

    seg7_scan_reader #(
        .NUM_DIGITS    (N),
        .STABLE_CYCLES (SC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .an_in       (an_in),
        .seg_in      (seg_in),
        .digits_out  (digits_out),
        .blank_out   (blank_out),
        .err_out     (err_out),
        .commit      (commit),
        .frame_valid (frame_valid)
    );

    always #5 clk = ~clk;

    // Index 10 is the blank pattern.
    logic [0:6] tbl [11];

    // Reference model: a value commits once, when it has been seen on SC+1
    // consecutive edges with exactly one anode low.
    logic [3:0]   m_dig [N];
    logic [N-1:0] m_blank, m_err, m_seen;
    logic [N-1:0] m_last_an;
    logic [0:6]   m_last_seg;
    int           m_run;
    logic         exp_commit, exp_frame;

    int cyc, obs_commits, obs_frames, last_commit_cyc;
    int errors, checks;

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_dig[i] = 4'd0;
        m_blank    = '1;
        m_err      = '0;
        m_seen     = '0;
        m_last_an  = '1;
        m_last_seg = '1;
        m_run      = 0;
    endtask

    task automatic model_step();
        int zeros, idx, code;
        exp_commit = 1'b0;
        exp_frame  = 1'b0;
        if (rst) begin
            model_reset();
            return;
        end
        if (an_in !== m_last_an || seg_in !== m_last_seg) begin
            m_last_an  = an_in;
            m_last_seg = seg_in;
            m_run      = 0;
        end else begin
            m_run++;
        end
        zeros = 0;
        idx   = 0;
        for (int i = 0; i < N; i++) begin
            if (!an_in[i]) begin
                zeros++;
                idx = i;
            end
        end
        if (m_run == SC && zeros == 1) begin
            exp_commit = 1'b1;
            code = -1;
            for (int d = 0; d < 11; d++) if (tbl[d] == seg_in) code = d;
            if (code >= 0 && code < 10) begin
                m_dig[idx]   = 4'(code);
                m_blank[idx] = 1'b0;
                m_err[idx]   = 1'b0;
            end else if (code == 10) begin
                m_dig[idx]   = 4'd0;
                m_blank[idx] = 1'b1;
                m_err[idx]   = 1'b0;
            end else begin
                m_err[idx] = 1'b1;
            end
            m_seen[idx] = 1'b1;
            if (&m_seen) begin
                exp_frame = 1'b1;
                m_seen    = '0;
            end
        end
    endtask

    function automatic logic [4*N-1:0] m_digits();
        logic [4*N-1:0] v;
        for (int i = 0; i < N; i++) v[4*i +: 4] = m_dig[i];
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        cyc++;
        if (commit) begin
            obs_commits++;
            last_commit_cyc = cyc;
        end
        if (frame_valid) obs_frames++;
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        an_in  = '1;
        seg_in = 7'b1111111;
        tick();
        tick();
        rst = 1'b0;
        checks++; if (digits_out !== 16'h0000) begin errors++; $display("FAIL reset_digits got=%h exp=0000", digits_out); end
        checks++; if (blank_out !== 4'b1111) begin errors++; $display("FAIL reset_blank got=%b exp=1111", blank_out); end
        checks++; if (err_out !== 4'b0000) begin errors++; $display("FAIL reset_err got=%b exp=0000", err_out); end
        checks++; if (commit !== 1'b0) begin errors++; $display("FAIL reset_commit got=%b exp=0", commit); end
        checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL reset_frame got=%b exp=0", frame_valid); end
    endtask

    task automatic test_single_digit();
        int c0;
        an_in  = 4'b1110;
        seg_in = tbl[2];
        c0     = obs_commits;
        for (int k = 1; k <= SC + 1; k++) begin
            tick();
            checks++;
            if (commit !== (k == SC + 1)) begin
                errors++;
                $display("FAIL single_commit edge=%0d got=%b exp=%b", k - 1, commit, k == SC + 1);
            end
        end
        checks++; if (digits_out[3:0] !== 4'd2) begin errors++; $display("FAIL single_digit0 got=%0d exp=2", digits_out[3:0]); end
        checks++; if (blank_out[0] !== 1'b0) begin errors++; $display("FAIL single_blank0 got=%b exp=0", blank_out[0]); end
        for (int k = 0; k < 6; k++) tick();
        checks++; if (obs_commits - c0 !== 1) begin errors++; $display("FAIL single_count got=%0d exp=1", obs_commits - c0); end
    endtask

    task automatic test_scan();
        int c0, f0;
        c0 = obs_commits;
        f0 = obs_frames;
        for (int d = 0; d < N; d++) begin
            an_in  = ~(N'(1) << d);
            seg_in = tbl[d + 1];
            for (int k = 0; k <= SC; k++) begin
                tick();
                checks++;
                if (commit !== exp_commit) begin errors++; $display("FAIL scan_commit cyc=%0d got=%b exp=%b", cyc, commit, exp_commit); end
                checks++;
                if (frame_valid !== exp_frame) begin errors++; $display("FAIL scan_frame cyc=%0d got=%b exp=%b", cyc, frame_valid, exp_frame); end
            end
        end
        checks++; if (digits_out !== 16'h4321) begin errors++; $display("FAIL scan_digits got=%h exp=4321", digits_out); end
        checks++; if (obs_commits - c0 !== 4) begin errors++; $display("FAIL scan_commits got=%0d exp=4", obs_commits - c0); end
        checks++; if (obs_frames - f0 !== 1) begin errors++; $display("FAIL scan_frames got=%0d exp=1", obs_frames - f0); end
    endtask

    task automatic test_glitch();
        int c0, r0;
        c0     = obs_commits;
        an_in  = 4'b1101;
        seg_in = tbl[3];
        for (int k = 0; k < 5; k++) tick();
        seg_in = 7'b0000111;
        tick();
        seg_in = tbl[3];
        r0     = cyc;
        for (int k = 0; k <= SC; k++) tick();
        checks++; if (obs_commits - c0 !== 1) begin errors++; $display("FAIL glitch_count got=%0d exp=1", obs_commits - c0); end
        checks++; if (last_commit_cyc - r0 !== SC + 1) begin errors++; $display("FAIL glitch_latency got=%0d exp=%0d", last_commit_cyc - r0, SC + 1); end
        checks++; if (digits_out[7:4] !== 4'd3) begin errors++; $display("FAIL glitch_digit1 got=%0d exp=3", digits_out[7:4]); end
        checks++; if (err_out[1] !== 1'b0) begin errors++; $display("FAIL glitch_err1 got=%b exp=0", err_out[1]); end
    endtask

    task automatic test_invalid();
        an_in  = 4'b1011;
        seg_in = 7'b1111110;
        for (int k = 0; k <= SC; k++) tick();
        checks++; if (err_out[2] !== 1'b1) begin errors++; $display("FAIL invalid_err2 got=%b exp=1", err_out[2]); end
        checks++; if (digits_out[11:8] !== 4'd3) begin errors++; $display("FAIL invalid_digit2 got=%0d exp=3", digits_out[11:8]); end
        seg_in = tbl[8];
        for (int k = 0; k <= SC; k++) tick();
        checks++; if (digits_out[11:8] !== 4'd8) begin errors++; $display("FAIL recover_digit2 got=%0d exp=8", digits_out[11:8]); end
        checks++; if (err_out[2] !== 1'b0) begin errors++; $display("FAIL recover_err2 got=%b exp=0", err_out[2]); end
    endtask

    task automatic test_ghost();
        int c0;
        c0     = obs_commits;
        an_in  = 4'b1100;
        seg_in = tbl[1];
        for (int k = 0; k < 20; k++) tick();
        an_in = 4'b1111;
        for (int k = 0; k < 20; k++) tick();
        checks++; if (obs_commits - c0 !== 0) begin errors++; $display("FAIL ghost_commits got=%0d exp=0", obs_commits - c0); end
        checks++; if (digits_out !== m_digits()) begin errors++; $display("FAIL ghost_digits got=%h exp=%h", digits_out, m_digits()); end
        checks++; if (err_out !== m_err) begin errors++; $display("FAIL ghost_err got=%b exp=%b", err_out, m_err); end
    endtask

    task automatic test_reset_mid();
        int c0, r0;
        an_in  = 4'b0111;
        seg_in = tbl[5];
        for (int k = 0; k < 6; k++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (digits_out !== 16'h0000) begin errors++; $display("FAIL midrst_digits got=%h exp=0000", digits_out); end
        checks++; if (blank_out !== 4'b1111) begin errors++; $display("FAIL midrst_blank got=%b exp=1111", blank_out); end
        checks++; if (commit !== 1'b0) begin errors++; $display("FAIL midrst_commit got=%b exp=0", commit); end
        c0 = obs_commits;
        r0 = cyc;
        for (int k = 0; k <= SC; k++) tick();
        checks++; if (obs_commits - c0 !== 1) begin errors++; $display("FAIL midrst_count got=%0d exp=1", obs_commits - c0); end
        checks++; if (last_commit_cyc - r0 !== SC + 1) begin errors++; $display("FAIL midrst_latency got=%0d exp=%0d", last_commit_cyc - r0, SC + 1); end
        checks++; if (digits_out[15:12] !== 4'd5) begin errors++; $display("FAIL midrst_digit3 got=%0d exp=5", digits_out[15:12]); end
    endtask

    task automatic test_random();
        int len;
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(9, 0) < 8) an_in = ~(N'(1) << $urandom_range(N - 1, 0));
            else an_in = N'($urandom);
            if ($urandom_range(9, 0) < 7) seg_in = tbl[$urandom_range(10, 0)];
            else seg_in = 7'($urandom);
            len = $urandom_range(12, 1);
            for (int k = 0; k < len; k++) begin
                tick();
                checks++;
                if (commit !== exp_commit) begin errors++; $display("FAIL rand_commit cyc=%0d got=%b exp=%b", cyc, commit, exp_commit); end
                checks++;
                if (frame_valid !== exp_frame) begin errors++; $display("FAIL rand_frame cyc=%0d got=%b exp=%b", cyc, frame_valid, exp_frame); end
                checks++;
                if (digits_out !== m_digits() || blank_out !== m_blank || err_out !== m_err) begin
                    errors++;
                    $display("FAIL rand_state cyc=%0d got=%h/%b/%b exp=%h/%b/%b", cyc, digits_out,
                             blank_out, err_out, m_digits(), m_blank, m_err);
                end
            end
        end
    endtask

    initial begin
        tbl[0]  = 7'b0000001;
        tbl[1]  = 7'b1001111;
        tbl[2]  = 7'b0010010;
        tbl[3]  = 7'b0000110;
        tbl[4]  = 7'b1001100;
        tbl[5]  = 7'b0100100;
        tbl[6]  = 7'b0100000;
        tbl[7]  = 7'b0001111;
        tbl[8]  = 7'b0000000;
        tbl[9]  = 7'b0000100;
        tbl[10] = 7'b1111111;
        errors          = 0;
        checks          = 0;
        cyc             = 0;
        obs_commits     = 0;
        obs_frames      = 0;
        last_commit_cyc = 0;
        exp_commit      = 1'b0;
        exp_frame       = 1'b0;
        rst             = 1'b1;
        an_in           = '1;
        seg_in          = 7'b1111111;
        model_reset();
        #2;
        test_reset();
        test_single_digit();
        test_scan();
        test_glitch();
        test_invalid();
        test_ghost();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
